// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: power-of-two depth, wrapping pointers, full/empty from count.
// Storage is not reset; only pointers and count are.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter fed by a small transmit FIFO.
// Optional parity framing is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_BITS-1:0]         data_in,
  input  logic                         load,
  output logic                         ready,
  output logic                         busy,
  output logic                         serial_tx,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overrun
);

  localparam int                 BIT_W     = $clog2(DATA_BITS);
  localparam logic [15:0]        BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic               STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit                 PAR_ON    = (PARITY != PAR_NONE);

  // Without the parity build, the state after DATA is always STOP.
`ifdef UART_TX_PARITY_EN
  localparam tx_state_e PAR_STATE = ST_PARITY;
`else
  localparam tx_state_e PAR_STATE = ST_STOP;
`endif

  tx_state_e            state;
  tx_state_e            next_state;
  logic [15:0]          baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_end;
  logic                 tx_next;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  assign ready   = !full;
  assign push    = load && !full;
  assign bit_end = (baud_cnt == '0);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (data_in),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  logic par_bit;

  always_ff @(posedge clk) begin
    if (pop) par_bit <= parity_of(fifo_rd_data);
  end
`endif

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          next_state = ST_START;
          pop        = 1'b1;
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (bit_end) next_state = ST_DATA;
      end
      ST_DATA: begin
        tx_next = shift_reg[0];
        if (bit_end && (bit_idx == LAST_BIT)) next_state = PAR_ON ? PAR_STATE : ST_STOP;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_next = par_bit;
        if (bit_end) next_state = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more words are queued.
        if (bit_end && (stop_idx == STOP_LAST)) begin
          if (!empty) begin
            next_state = ST_START;
            pop        = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The line and busy are registered from the current state, so both lag it by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      serial_tx <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= next_state;
      serial_tx <= tx_next;
      busy      <= (state != ST_IDLE) || (fifo_count != '0);
      overrun   <= load && full;

      if (bit_end || (state == ST_IDLE)) baud_cnt <= BAUD_LAST;
      else                                baud_cnt <= baud_cnt - 16'd1;

      if (state != ST_DATA) bit_idx <= '0;
      else if (bit_end)     bit_idx <= bit_idx + BIT_W'(1);

      if (state != ST_STOP) stop_idx <= 1'b0;
      else if (bit_end)     stop_idx <= ~stop_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                               shift_reg <= fifo_rd_data;
    else if ((state == ST_DATA) && bit_end) shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: framing, parity, FIFO back-pressure and reset.
// Expected parity frames depend on whether UART_TX_PARITY_EN is defined.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic [3:0] ld;
  logic [3:0] tx, bsy, rdy, ovr;
  logic [2:0] fc0, fc1, fc2, fc3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] cap [8];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(din), .load(ld[0]), .ready(rdy[0]),
    .busy(bsy[0]), .serial_tx(tx[0]), .fifo_count(fc0), .overrun(ovr[0]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2), .PARITY(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(din[4:0]), .load(ld[1]), .ready(rdy[1]),
    .busy(bsy[1]), .serial_tx(tx[1]), .fifo_count(fc1), .overrun(ovr[1]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .data_in(din), .load(ld[2]), .ready(rdy[2]),
    .busy(bsy[2]), .serial_tx(tx[2]), .fifo_count(fc2), .overrun(ovr[2]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(4)) dut_d (
    .clk(clk), .reset_n(reset_n), .data_in(din), .load(ld[3]), .ready(rdy[3]),
    .busy(bsy[3]), .serial_tx(tx[3]), .fifo_count(fc3), .overrun(ovr[3]));

  typedef struct {
    int          k;
    logic [7:0]  data;
    int          nb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Returns just after the edge that accepts the word.
  task automatic load_word(input int k, input logic [7:0] d);
    din   = d;
    ld[k] = 1'b1;
    tick();
    ld[k] = 1'b0;
  endtask

  // Called just after the accepting edge; captures nf back-to-back frames of nb bits (4 clk/bit).
  task automatic frame_run(input int k, input int nf, input int nb, input string nm);
    int last;
    last = 2 + nf * nb * 4;
    for (int j = 0; j < 8; j++) cap[j] = '0;
    for (int t = 1; t <= last; t++) begin
      tick();
      if (t == 1) chk({nm, "_tx_before_fall"}, 32'(tx[k]), 32'd1);
      if (t == 2) chk({nm, "_tx_fall_at_2"}, 32'(tx[k]), 32'd0);
      if ((t >= 3) && (((t - 3) % 4) == 0)) begin
        int idx;
        idx = (t - 3) / 4;
        if (idx < nf * nb) cap[idx / nb][idx % nb] = tx[k];
      end
      if (t == last - 1) chk({nm, "_busy_in_stop"}, 32'(bsy[k]), 32'd1);
      if (t == last) begin
        chk({nm, "_busy_after"}, 32'(bsy[k]), 32'd0);
        chk({nm, "_tx_idle_after"}, 32'(tx[k]), 32'd1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 8'h00, 10, 16'h200};
    vecs[1]  = '{0, 8'hFF, 10, 16'h3FE};
    vecs[2]  = '{0, 8'h01, 10, 16'h202};
    vecs[3]  = '{0, 8'h80, 10, 16'h300};
    vecs[4]  = '{0, 8'hAA, 10, 16'h354};
    vecs[5]  = '{0, 8'h55, 10, 16'h2AA};
    vecs[6]  = '{1, 8'h1F,  8, 16'h0FE};
    vecs[7]  = '{1, 8'h0A,  8, 16'h0D4};
`ifdef UART_TX_PARITY_EN
    vecs[8]  = '{2, 8'h07, 11, 16'h60E};
    vecs[9]  = '{2, 8'h03, 11, 16'h406};
    vecs[10] = '{3, 8'h07, 11, 16'h40E};
    vecs[11] = '{3, 8'h03, 11, 16'h606};
`else
    vecs[8]  = '{2, 8'h07, 10, 16'h20E};
    vecs[9]  = '{2, 8'h03, 10, 16'h206};
    vecs[10] = '{3, 8'h07, 10, 16'h20E};
    vecs[11] = '{3, 8'h03, 10, 16'h206};
`endif

    reset_n = 1'b1;
    din     = '0;
    ld      = '0;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_tx",      32'(tx),  32'hF);
    chk("rst_busy",    32'(bsy), 32'h0);
    chk("rst_ready",   32'(rdy), 32'hF);
    chk("rst_overrun", 32'(ovr), 32'h0);
    chk("rst_count",   32'({fc0, fc1, fc2, fc3}), 32'h0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      load_word(vecs[i].k, vecs[i].data);
      frame_run(vecs[i].k, 1, vecs[i].nb, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_frame", i), 32'(cap[0]), 32'(vecs[i].exp));
    end

    // Frame length for 5 data bits and 2 stop bits.
    begin
      int t_fall;
      int t_end;
      t_fall = -1;
      t_end  = -1;
      load_word(1, 8'h1F);
      for (int t = 1; t <= 100; t++) begin
        tick();
        if ((t_fall < 0) && (tx[1] == 1'b0)) t_fall = t;
        else if ((t_fall >= 0) && (bsy[1] == 1'b0) && (t_end < 0)) t_end = t;
      end
      chk("len_5n2_cycles", 32'(t_end - t_fall), 32'd32);
    end

    // Five loads while a frame is on the line: four queue, the fifth overruns.
    begin
      logic [7:0] words [6];
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      load_word(0, words[0]);
      fork
        begin
          int extra;
          extra = 0;
          tick();
          for (int w = 1; w <= 5; w++) begin
            din   = words[w];
            ld[0] = 1'b1;
            if (w < 5) tick();
          end
          chk("fifo_count_full", 32'(fc0), 32'd4);
          chk("fifo_ready_low", 32'(rdy[0]), 32'd0);
          chk("fifo_no_early_ovr", 32'(ovr[0]), 32'd0);
          tick();
          ld[0] = 1'b0;
          chk("fifo_ovr_pulse", 32'(ovr[0]), 32'd1);
          chk("fifo_count_kept", 32'(fc0), 32'd4);
          tick();
          chk("fifo_ovr_one_cycle", 32'(ovr[0]), 32'd0);
          repeat (190) begin
            tick();
            if (ovr[0]) extra++;
          end
          chk("fifo_ovr_extra", 32'(extra), 32'd0);
        end
        frame_run(0, 5, 10, "fifo");
      join
      for (int j = 0; j < 5; j++)
        chk($sformatf("fifo_frame%0d", j), 32'(cap[j]), 32'({6'b0, 1'b1, words[j], 1'b0}));
      chk("fifo_count_empty", 32'(fc0), 32'd0);
    end

    // Reset in the middle of a data bit that is low, with one word still queued.
    load_word(0, 8'h0F);
    din   = 8'h3C;
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    chk("mid_count_pre", 32'(fc0), 32'd1);
    repeat (22) tick();
    chk("mid_tx_low_pre", 32'(tx[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_tx_now", 32'(tx[0]), 32'd1);
    chk("mid_count_now", 32'(fc0), 32'd0);
    chk("mid_busy_now", 32'(bsy[0]), 32'd0);
    chk("mid_ready_now", 32'(rdy[0]), 32'd1);
    tick();
    chk("mid_tx_held", 32'(tx[0]), 32'd1);
    reset_n = 1'b1;
    tick();
    load_word(0, 8'hAA);
    frame_run(0, 1, 10, "post_rst");
    chk("post_rst_frame", 32'(cap[0]), 32'h354);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
